display_scan_ctrl: RTL and testbench
====================================

// Module: display_scan_ctrl
// PURPOSE
//  Refresh scheduler for the 4-digit common-anode 7-segment display. Time-multiplexes
//  four symbol slots onto shared seg/an lines and inserts a blanking gap between digits
//  to stop ghosting. Symbols are double-buffered, with an atomic commit at frame boundary.
//  Sits between the colour/counter logic (writers) and the board display pins.
// PARAMETERS
//  TICKS_ON     50000  clk cycles a digit is driven per slot (>=1)
//  TICKS_BLANK  500    clk cycles all anodes off after each slot (0 = no blank phase)
// PORTS
//  clk         in   1  system clock
//  rst         in   1  synchronous, active-low reset
//  enable      in   1  1 = scan running; 0 = display dark
//  wr_en       in   1  write wr_data into shadow slot wr_addr this cycle
//  wr_addr     in   2  shadow slot index (0 = rightmost digit, an[0])
//  wr_data     in   5  symbol code (see encoding)
//  commit      in   1  request shadow->active copy at next frame start
//  digit_mask  in   4  1 = digit forced dark during its slot (timing unchanged)
//  seg         out  7  {g,f,e,d,c,b,a}, active-low
//  an          out  4  anode enables, active-low, at most one low
//  frame_done  out  1  1-cycle pulse when digit 3 slot (incl. blank) completes
//  commit_ack  out  1  1-cycle pulse in the cycle shadow is copied to active
// BEHAVIOUR
//  Encoding (seg): 0..9 standard decimal (0=1000000, 1=1111001, 2=0100100, 3=0110000,
//   4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000);
//   10 'r'=0101111, 11 'g'=0010000, 12 'b'=0000011, 13 '-'=0111111, 14..31 blank=1111111.
//  Reset (rst=0 at posedge): state IDLE, digit=0, counter=0, pending=0; all shadow and
//   active slots=14. Outputs: an=1111, seg=1111111, frame_done=0, commit_ack=0.
//   Reset mid-scan aborts immediately. Reset takes priority over all inputs.
//  seg/an are registered and change on the same edge as the state/digit they reflect.
//  Writes: wr_en updates shadow[wr_addr] at the edge and is always accepted.
//   Active slots never change except by commit.
//  commit sets pending (sticky). Copy happens on each ON entry for digit 0: wrap from
//   digit 3, or IDLE->ON. wr_en and commit in the same cycle: that write is included.
//   Writes after the pending edge are also included until the copy edge.
//   Copy edge: active<=shadow, pending<=0, commit_ack=1; new values are displayed in that slot.
//  FSM:
//   IDLE : an=1111, seg blank. enable=1 -> ON, digit 0, count=0 (1-cycle latency).
//   ON   : an[digit]=0 unless digit_mask[digit] (then an=1111). seg=dec(active[digit]),
//          or blank if masked. After TICKS_ON cycles -> BLANK; if TICKS_BLANK=0,
//          advance directly as from BLANK end.
//   BLANK: an=1111, seg blank for TICKS_BLANK cycles. Then digit<=digit+1 (3 wraps to 0)
//          -> ON. On wrap, frame_done=1 on that edge.
//   enable=0 in any state -> IDLE at next edge; digit/count cleared; pending kept.
//  Slot period = TICKS_ON+TICKS_BLANK; frame = 4x slot. Counter width is clog2 of the
//   max tick value; it never overflows.
// TESTING (TICKS_ON=4, TICKS_BLANK=2)
//  Reset, enable=0 for 20 cycles -> an=1111, seg=1111111, no pulses.
//  Write slots 0..3 = 10,11,12,13, commit, enable -> commit_ack with first ON. Then repeating
//   an 1110x4,1111x2,1101x4,1111x2,1011x4,1111x2,0111x4,1111x2 with
//   seg 0101111/0010000/0000011/0111111; frame_done every 24 cycles.
//  Mid-frame write slot0=5 without commit -> display unchanged. Commit during digit 2 ->
//   at next wrap commit_ack=1 and digit 0 seg=0010010.
//  digit_mask=0010 -> digit1 slot shows an=1111 for 4 cycles; frame still 24 cycles.
//  TICKS_BLANK=0 build -> an steps 1110->1101 with no gap; frame = 16 cycles.
//  rst low during digit 2 ON -> next edge an=1111, all slots 14; enable resumes digit 0 blank.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Refresh scheduler for a 4-digit common-anode 7-segment display.
// Double-buffered symbol slots, per-digit blanking gap, atomic commit at frame start.
module display_scan_ctrl #(
    parameter int unsigned TICKS_ON    = 50000,
    parameter int unsigned TICKS_BLANK = 500
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       wr_en,
    input  logic [1:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic       commit,
    input  logic [3:0] digit_mask,
    output logic [6:0] seg,
    output logic [3:0] an,
    output logic       frame_done,
    output logic       commit_ack
);

    localparam int unsigned TMAX = (TICKS_ON > TICKS_BLANK) ? TICKS_ON : TICKS_BLANK;
    localparam int unsigned CW   = (TMAX > 1) ? $clog2(TMAX) : 1;
    localparam logic [CW-1:0] ON_LAST    = CW'(TICKS_ON - 1);
    localparam logic [CW-1:0] BLANK_LAST = CW'((TICKS_BLANK > 0) ? TICKS_BLANK - 1 : 0);
    localparam logic [4:0]    SYM_BLANK  = 5'd14;

    typedef enum logic [1:0] {
        S_IDLE,
        S_ON,
        S_BLANK
    } state_t;

    state_t          r_state, w_state_nx;
    logic [1:0]      r_digit, w_digit_nx;
    logic [CW-1:0]   r_count, w_count_nx;
    logic            r_pending, w_pending_nx;
    logic [4:0]      r_shadow [4];
    logic [4:0]      r_active [4];
    logic [4:0]      w_shadow_nx [4];
    logic [4:0]      w_active_nx [4];
    logic            w_adv, w_wrap, w_enter0, w_copy;
    logic [6:0]      w_seg_nx;
    logic [3:0]      w_an_nx;

    function automatic logic [6:0] dec(input logic [4:0] sym);
        case (sym)
            5'd0:    dec = 7'b1000000;
            5'd1:    dec = 7'b1111001;
            5'd2:    dec = 7'b0100100;
            5'd3:    dec = 7'b0110000;
            5'd4:    dec = 7'b0011001;
            5'd5:    dec = 7'b0010010;
            5'd6:    dec = 7'b0000010;
            5'd7:    dec = 7'b1111000;
            5'd8:    dec = 7'b0000000;
            5'd9:    dec = 7'b0010000;
            5'd10:   dec = 7'b0101111;
            5'd11:   dec = 7'b0010000;
            5'd12:   dec = 7'b0000011;
            5'd13:   dec = 7'b0111111;
            default: dec = 7'b1111111;
        endcase
    endfunction

    always_comb begin
        w_state_nx = r_state;
        w_digit_nx = r_digit;
        w_count_nx = r_count;
        w_adv      = 1'b0;
        w_enter0   = 1'b0;
        if (!enable) begin
            w_state_nx = S_IDLE;
            w_digit_nx = '0;
            w_count_nx = '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    w_state_nx = S_ON;
                    w_digit_nx = '0;
                    w_count_nx = '0;
                    w_enter0   = 1'b1;
                end
                S_ON: begin
                    if (r_count == ON_LAST) begin
                        if (TICKS_BLANK == 0) begin
                            w_adv = 1'b1;
                        end else begin
                            w_state_nx = S_BLANK;
                            w_count_nx = '0;
                        end
                    end else begin
                        w_count_nx = r_count + 1'b1;
                    end
                end
                S_BLANK: begin
                    if (r_count == BLANK_LAST) w_adv = 1'b1;
                    else                       w_count_nx = r_count + 1'b1;
                end
                default: w_state_nx = S_IDLE;
            endcase
        end
        w_wrap = w_adv && (r_digit == 2'd3);
        if (w_adv) begin
            w_state_nx = S_ON;
            w_digit_nx = r_digit + 1'b1;
            w_count_nx = '0;
            if (w_wrap) w_enter0 = 1'b1;
        end
    end

    // A write landing on the copy edge is forwarded so it is part of the commit.
    always_comb begin
        w_shadow_nx = r_shadow;
        if (wr_en) w_shadow_nx[wr_addr] = wr_data;
        w_copy       = w_enter0 && (r_pending || commit);
        w_active_nx  = w_copy ? w_shadow_nx : r_active;
        w_pending_nx = w_copy ? 1'b0 : (r_pending || commit);
    end

    // Outputs are computed from next-state values so they change on the same edge.
    always_comb begin
        w_seg_nx = 7'b1111111;
        w_an_nx  = 4'b1111;
        if (w_state_nx == S_ON && !digit_mask[w_digit_nx]) begin
            w_an_nx  = ~(4'b0001 << w_digit_nx);
            w_seg_nx = dec(w_active_nx[w_digit_nx]);
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state    <= S_IDLE;
            r_digit    <= '0;
            r_count    <= '0;
            r_pending  <= 1'b0;
            for (int unsigned i = 0; i < 4; i++) begin
                r_shadow[i] <= SYM_BLANK;
                r_active[i] <= SYM_BLANK;
            end
            seg        <= 7'b1111111;
            an         <= 4'b1111;
            frame_done <= 1'b0;
            commit_ack <= 1'b0;
        end else begin
            r_state    <= w_state_nx;
            r_digit    <= w_digit_nx;
            r_count    <= w_count_nx;
            r_pending  <= w_pending_nx;
            r_shadow   <= w_shadow_nx;
            r_active   <= w_active_nx;
            seg        <= w_seg_nx;
            an         <= w_an_nx;
            frame_done <= w_wrap;
            commit_ack <= w_copy;
        end
    end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized bench for display_scan_ctrl; two builds (blank gap 2 and 0) against a
// time-since-scan-start reference model.
module tb_display_scan_ctrl;

    localparam int TON = 4;

    logic       clk = 1'b0;
    logic       rst, enable, wr_en, commit;
    logic [1:0] wr_addr;
    logic [4:0] wr_data;
    logic [3:0] digit_mask;
    logic [6:0] seg_a, seg_b;
    logic [3:0] an_a, an_b;
    logic       fd_a, fd_b, ack_a, ack_b;

    int n_vec = 0;
    int n_err = 0;

    logic [6:0] seg_tab [32];
    int         m_run [2];
    int         m_t [2];
    logic [4:0] m_sh [2][4];
    logic [4:0] m_ac [2][4];
    logic       m_pend [2];
    logic [6:0] e_seg [2];
    logic [3:0] e_an [2];
    logic       e_fd [2];
    logic       e_ack [2];

    always #5 clk = ~clk;

    display_scan_ctrl #(.TICKS_ON(TON), .TICKS_BLANK(2)) dut_a (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .digit_mask(digit_mask),
        .seg(seg_a), .an(an_a), .frame_done(fd_a), .commit_ack(ack_a)
    );

    display_scan_ctrl #(.TICKS_ON(TON), .TICKS_BLANK(0)) dut_b (
        .clk(clk), .rst(rst), .enable(enable), .wr_en(wr_en), .wr_addr(wr_addr),
        .wr_data(wr_data), .commit(commit), .digit_mask(digit_mask),
        .seg(seg_b), .an(an_b), .frame_done(fd_b), .commit_ack(ack_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %0h expected %0h", tag, $time, obs, exp);
        end
    endtask

    // Position in the scan is derived purely from cycles elapsed since the scan started.
    task automatic model_step(input int k, input int tb);
        int slot_len, frame, slot;
        slot_len = TON + tb;
        frame    = 4 * slot_len;
        e_seg[k] = 7'b1111111;
        e_an[k]  = 4'b1111;
        e_fd[k]  = 1'b0;
        e_ack[k] = 1'b0;
        if (!rst) begin
            m_run[k]  = 0;
            m_t[k]    = 0;
            m_pend[k] = 1'b0;
            for (int i = 0; i < 4; i++) begin
                m_sh[k][i] = 5'd14;
                m_ac[k][i] = 5'd14;
            end
        end else begin
            if (wr_en) m_sh[k][wr_addr] = wr_data;
            if (commit) m_pend[k] = 1'b1;
            if (!enable) begin
                m_run[k] = 0;
            end else begin
                if (m_run[k] != 0) m_t[k]++;
                else begin
                    m_run[k] = 1;
                    m_t[k]   = 0;
                end
                e_fd[k] = (m_t[k] > 0) && (m_t[k] % frame == 0);
                if ((m_t[k] % frame == 0) && m_pend[k]) begin
                    for (int i = 0; i < 4; i++) m_ac[k][i] = m_sh[k][i];
                    m_pend[k] = 1'b0;
                    e_ack[k]  = 1'b1;
                end
                slot = (m_t[k] / slot_len) % 4;
                if ((m_t[k] % slot_len) < TON && !digit_mask[slot]) begin
                    e_an[k]  = 4'b1111 & ~(4'b0001 << slot);
                    e_seg[k] = seg_tab[m_ac[k][slot]];
                end
            end
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        model_step(0, 2);
        model_step(1, 0);
        #1;
        chk("seg_a", 32'(seg_a), 32'(e_seg[0]));
        chk("an_a",  32'(an_a),  32'(e_an[0]));
        chk("fd_a",  32'(fd_a),  32'(e_fd[0]));
        chk("ack_a", 32'(ack_a), 32'(e_ack[0]));
        chk("seg_b", 32'(seg_b), 32'(e_seg[1]));
        chk("an_b",  32'(an_b),  32'(e_an[1]));
        chk("fd_b",  32'(fd_b),  32'(e_fd[1]));
        chk("ack_b", 32'(ack_b), 32'(e_ack[1]));
        wr_en  = 1'b0;
        commit = 1'b0;
    endtask

    task automatic write_slot(input int a, input int d);
        wr_en   = 1'b1;
        wr_addr = 2'(a);
        wr_data = 5'(d);
        cycle();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) seg_tab[i] = 7'b1111111;
        seg_tab[0]  = 7'b1000000; seg_tab[1]  = 7'b1111001; seg_tab[2]  = 7'b0100100;
        seg_tab[3]  = 7'b0110000; seg_tab[4]  = 7'b0011001; seg_tab[5]  = 7'b0010010;
        seg_tab[6]  = 7'b0000010; seg_tab[7]  = 7'b1111000; seg_tab[8]  = 7'b0000000;
        seg_tab[9]  = 7'b0010000; seg_tab[10] = 7'b0101111; seg_tab[11] = 7'b0010000;
        seg_tab[12] = 7'b0000011; seg_tab[13] = 7'b0111111;

        rst = 1'b0; enable = 1'b0; wr_en = 1'b0; commit = 1'b0;
        wr_addr = '0; wr_data = '0; digit_mask = '0;
        repeat (3) cycle();
        rst = 1'b1;
        repeat (20) cycle();

        write_slot(0, 10); write_slot(1, 11); write_slot(2, 12); write_slot(3, 13);
        commit = 1'b1;
        cycle();
        enable = 1'b1;
        repeat (60) cycle();

        // mid-frame write without commit, then commit during digit 2
        write_slot(0, 5);
        repeat (30) cycle();
        repeat (14) cycle();
        commit = 1'b1;
        repeat (40) cycle();

        digit_mask = 4'b0010;
        repeat (50) cycle();
        digit_mask = 4'b0000;
        repeat (13) cycle();
        rst = 1'b0;
        cycle();
        rst = 1'b1;
        repeat (30) cycle();

        for (int n = 0; n < 4000; n++) begin
            if ($urandom_range(0, 7) == 0) begin
                wr_en   = 1'b1;
                wr_addr = 2'($urandom_range(0, 3));
                wr_data = 5'($urandom_range(0, 31));
            end
            if ($urandom_range(0, 29) == 0) commit = 1'b1;
            if ($urandom_range(0, 59) == 0) digit_mask = 4'($urandom_range(0, 15));
            if ($urandom_range(0, 149) == 0) enable = ~enable;
            rst = ($urandom_range(0, 699) != 0);
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
